// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared data/address width, FSM state encoding and default reset PC.
`ifndef WIDTH
`define WIDTH 32
`endif
package fetch_stage_pkg;
    localparam int WIDTH = `WIDTH;
    localparam logic [WIDTH-1:0] DEFAULT_RESET_PC = '0;
    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        BUFFERED = 2'd1,
        REDIRECT = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding register for a word fetched while decode is stalled.
module fetch_skid_buf #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic         rd,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            dout <= '0;
        end else if (clr) begin
            full <= 1'b0;
            dout <= '0;
        end else if (wr) begin
            full <= 1'b1;
            dout <= din;
        end else if (rd) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC/instruction-fetch stage with skid buffer and branch redirect.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [`WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [`WIDTH-1:0] branch_target,
    output logic              imem_req,
    output logic [`WIDTH-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              if_id_valid,
    output logic [31:0]       if_id_instr,
    output logic [`WIDTH-1:0] if_id_pc4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);
    fetch_state_t state, state_d;
    logic [`WIDTH-1:0] pc, pc_d, pc4, redir, redir_d;
    logic hs, br, ld_mem, ld_skid, bubble, skid_wr, skid_full;
    logic [31+`WIDTH:0] skid_dout;

    assign pc4       = pc + `WIDTH'(4);
    assign imem_addr = pc;
    assign imem_req  = state != BUFFERED;
    assign hs        = imem_req & imem_ready;
    assign br        = branch_taken & ~stall;
    assign bubble    = ~stall & ~ld_mem & ~ld_skid;

    fetch_skid_buf #(.W(32 + `WIDTH)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .wr   (skid_wr),
        .rd   (ld_skid),
        .clr  (br),
        .din  ({imem_rdata, pc4}),
        .dout (skid_dout),
        .full (skid_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
            redir <= '0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            redir <= redir_d;
        end
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        redir_d = redir;
        ld_mem  = 1'b0;
        ld_skid = 1'b0;
        skid_wr = 1'b0;
        unique case (state)
            FETCH: begin
                if (br) begin
                    pc_d    = hs ? branch_target : pc;
                    redir_d = hs ? redir : branch_target;
                    state_d = hs ? FETCH : REDIRECT;
                end else if (hs) begin
                    pc_d    = pc4;
                    ld_mem  = ~stall;
                    skid_wr = stall;
                    state_d = stall ? BUFFERED : FETCH;
                end
            end
            BUFFERED: begin
                if (br) begin
                    pc_d    = branch_target;
                    state_d = FETCH;
                end else if (!stall) begin
                    ld_skid = skid_full;
                    state_d = FETCH;
                end
            end
            REDIRECT: begin
                // A younger branch retargets the in-flight discard instead of the old target
                if (br) begin
                    pc_d    = hs ? branch_target : pc;
                    redir_d = hs ? redir : branch_target;
                    state_d = hs ? FETCH : REDIRECT;
                end else if (hs) begin
                    pc_d    = redir;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc4   <= '0;
        end else if (ld_mem) begin
            if_id_valid <= 1'b1;
            if_id_instr <= imem_rdata;
            if_id_pc4   <= pc4;
        end else if (ld_skid) begin
            if_id_valid <= 1'b1;
            {if_id_instr, if_id_pc4} <= skid_dout;
        end else if (bubble) begin
            if_id_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'(ld_mem | ld_skid);
            perf_flush_cnt <= perf_flush_cnt + 32'(br);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a scoreboard monitor on the IF/ID register.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif
    int checks = 0;
    int errors = 0;
    int exp_fetch = 0;
    int exp_flush = 0;
    logic st_q = 1'b1;
    logic [63:0] sb[$];
    logic [63:0] e;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] w(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    // One cycle of stimulus; ea/er are the address and request expected this cycle.
    task automatic cyc(input logic s, input logic b, input logic [31:0] tgt, input logic r,
                       input logic [31:0] rd, input logic [31:0] ea, input logic er,
                       input logic push);
        stall = s;
        branch_taken = b;
        branch_target = tgt;
        imem_ready = r;
        imem_rdata = rd;
        chk("imem_addr", imem_addr, ea);
        chk("imem_req", {31'b0, imem_req}, {31'b0, er});
        if (push) begin
            sb.push_back({rd, ea + 32'd4});
            exp_fetch++;
        end
        if (b && !s) exp_flush++;
        @(negedge clk);
    endtask

    always @(posedge clk) st_q <= stall;

    // A fresh IF/ID entry appears only after an edge with stall low.
    always @(negedge clk) begin
        if (!rst && !st_q && if_id_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_entry: got instr %h pc4 %h expected no entry", if_id_instr, if_id_pc4);
            end else begin
                e = sb.pop_front();
                chk("if_id_instr", if_id_instr, e[63:32]);
                chk("if_id_pc4", if_id_pc4, e[31:0]);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
        chk("rst_instr", if_id_instr, 32'd0);
        chk("rst_pc4", if_id_pc4, 32'd0);
        rst = 1'b0;
        cyc(0, 0, 0, 1, w(32'h0), 32'h0, 1, 1);
        cyc(0, 0, 0, 1, w(32'h4), 32'h4, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, w(32'h8), 32'h8, 1, 0);
            chk("wait_bubble", {31'b0, if_id_valid}, 32'd0);
        end
        cyc(0, 0, 0, 1, w(32'h8), 32'h8, 1, 1);
        cyc(0, 1, 32'h40, 1, w(32'hC), 32'hC, 1, 0);
        chk("br_hs_bubble", {31'b0, if_id_valid}, 32'd0);
        cyc(0, 0, 0, 1, w(32'h40), 32'h40, 1, 1);
        cyc(0, 1, 32'h80, 0, w(32'h44), 32'h44, 1, 0);
        chk("br_wait_bubble", {31'b0, if_id_valid}, 32'd0);
        cyc(0, 0, 0, 0, w(32'h44), 32'h44, 1, 0);
        cyc(0, 0, 0, 1, w(32'h44), 32'h44, 1, 0);
        chk("redirect_discard", {31'b0, if_id_valid}, 32'd0);
        cyc(0, 1, 32'h100, 0, w(32'h80), 32'h80, 1, 0);
        cyc(0, 1, 32'h200, 0, w(32'h80), 32'h80, 1, 0);
        cyc(0, 0, 0, 1, w(32'h80), 32'h80, 1, 0);
        cyc(0, 0, 0, 1, w(32'h200), 32'h200, 1, 1);
        cyc(1, 0, 0, 1, 32'h8C080004, 32'h204, 1, 1);
        chk("stall_hold_valid", {31'b0, if_id_valid}, 32'd1);
        chk("stall_hold_instr", if_id_instr, w(32'h200));
        cyc(1, 1, 32'h300, 1, w(32'h208), 32'h208, 0, 0);
        chk("stall_hold_pc4", if_id_pc4, 32'h204);
        cyc(0, 0, 0, 0, 32'h0, 32'h208, 0, 0);
        cyc(0, 0, 0, 1, w(32'h208), 32'h208, 1, 1);
        cyc(0, 1, 32'hFFFF_FFFC, 1, w(32'h20C), 32'h20C, 1, 0);
        cyc(0, 0, 0, 1, w(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1, 1);
        cyc(0, 0, 0, 0, 32'h0, 32'h0, 1, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch_cnt", perf_fetch_cnt, 32'(exp_fetch));
        chk("perf_flush_cnt", perf_flush_cnt, 32'(exp_flush));
`endif
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_valid", {31'b0, if_id_valid}, 32'd0);
        chk("rst2_addr", imem_addr, 32'h0);
        chk("rst2_req", {31'b0, imem_req}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("rst2_perf_fetch", perf_fetch_cnt, 32'd0);
`endif
        imem_ready = 1'b0;
        rst = 1'b0;
        cyc(0, 0, 0, 0, 32'h0, 32'h0, 1, 0);
        chk("rst2_no_entry", {31'b0, if_id_valid}, 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
